// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter.
//   arb_state_t : arbiter FSM states (IDLE -> REQ -> WAIT -> IDLE)
//   mem_owner_t : which requester owns the outstanding memory transaction
//   other_owner : returns the opposite requester (used for alternating grants)
package imem_dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_FETCH = 1'b0,
    OWNER_DATA  = 1'b1
  } mem_owner_t;

  function automatic mem_owner_t other_owner(input mem_owner_t o);
    return (o == OWNER_DATA) ? OWNER_FETCH : OWNER_DATA;
  endfunction

endpackage

// File: rtl/imem_dmem_arbiter_arb_priority.sv
// Combinational grant picker for the memory arbiter.
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   undefined : data always beats fetch (fetch can starve under a d_req stream)
//   defined   : on a contested request the loser of the previous contest wins
// Ports:
//   d_req_i      data request
//   if_req_i     fetch request
//   last_owner_i winner of the previous contested arbitration
//   grant_o      chosen requester (only meaningful when a request is present)
module imem_dmem_arbiter_arb_priority
  import imem_dmem_arbiter_pkg::*;
(
  input  logic       d_req_i,
  input  logic       if_req_i,
  input  mem_owner_t last_owner_i,
  output mem_owner_t grant_o
);

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    if (d_req_i && if_req_i) grant_o = other_owner(last_owner_i);
    else if (d_req_i)        grant_o = OWNER_DATA;
    else                     grant_o = OWNER_FETCH;
  end
`else
  // History is irrelevant with fixed priority.
  logic unused_last_owner;
  assign unused_last_owner = last_owner_i;

  always_comb grant_o = d_req_i ? OWNER_DATA : OWNER_FETCH;
`endif

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// One transaction outstanding at a time; completion is a one-cycle valid
// pulse to the owning requester, used by the pipeline as ready/stall.
// Optional feature macro: ARB_ROUND_ROBIN_EN (alternating grants on contention,
// resolved inside imem_dmem_arbiter_arb_priority).
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   if_req/if_addr             fetch request, held until if_valid
//   if_rdata/if_valid          fetch data + completion pulse
//   d_req/d_addr/d_wdata/d_be/d_we  data request, held until d_valid
//   d_rdata/d_valid            load data + completion pulse
//   mem_req/mem_ready          memory request handshake
//   mem_addr/mem_wdata/mem_be/mem_we  registered request fields
//   mem_rdata/mem_rvalid       memory response / write acknowledge
//   err                        one-cycle pulse on a response timeout
module imem_dmem_arbiter
  import imem_dmem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_valid,
  input  logic                    d_req,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  input  logic                    d_we,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_valid,
  output logic                    mem_req,
  input  logic                    mem_ready,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic                    mem_we,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_rvalid,
  output logic                    err
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  // The counter reads 0 in the first WAIT cycle, so the abort cycle is the
  // one in which it is about to reach TIMEOUT.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BE_W-1:0]       be;
    logic                  we;
  } mem_req_t;

  arb_state_t       state_q, state_d;
  mem_owner_t       owner_q, owner_d;
  mem_owner_t       last_owner_q, last_owner_d;
  mem_owner_t       grant;
  mem_req_t         req_q, req_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout;
  logic             done;

  imem_dmem_arbiter_arb_priority u_arb_priority (
    .d_req_i      (d_req),
    .if_req_i     (if_req),
    .last_owner_i (last_owner_q),
    .grant_o      (grant)
  );

  // A response in the abort cycle still counts as a normal completion.
  assign timeout = (state_q == ARB_WAIT) && !mem_rvalid && (cnt_q >= CNT_LAST);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    req_d        = req_q;
    cnt_d        = cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (d_req || if_req) begin
          state_d = ARB_REQ;
          owner_d = grant;
          if (d_req && if_req) last_owner_d = grant;
          if (grant == OWNER_DATA) begin
            req_d.addr  = d_addr;
            req_d.wdata = d_wdata;
            req_d.be    = d_be;
            req_d.we    = d_we;
          end else begin
            req_d.addr  = if_addr;
            req_d.wdata = '0;
            req_d.be    = '1;
            req_d.we    = 1'b0;
          end
        end
      end
      ARB_REQ: begin
        if (mem_ready) begin
          state_d = ARB_WAIT;
          cnt_d   = '0;
        end
      end
      ARB_WAIT: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        if (mem_rvalid || timeout) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      owner_q      <= OWNER_DATA;
      last_owner_q <= OWNER_DATA;
      req_q        <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      req_q        <= req_d;
      cnt_q        <= cnt_d;
    end
  end

  assign mem_req   = (state_q == ARB_REQ);
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;
  assign mem_be    = req_q.be;
  assign mem_we    = req_q.we;

  // Completion pulses are gated by rst_n so a reset cycle never reports one.
  assign done     = rst_n && (state_q == ARB_WAIT) && (mem_rvalid || timeout);
  assign if_valid = done && (owner_q == OWNER_FETCH);
  assign d_valid  = done && (owner_q == OWNER_DATA);
  assign err      = rst_n && timeout;

  // Both requesters see the same bus; only the owner's copy is meaningful.
  assign if_rdata = mem_rvalid ? mem_rdata : '0;
  assign d_rdata  = mem_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
module tb_imem_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int TO = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          d_req = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [BW-1:0] d_be = '0;
  logic          d_we = 1'b0;
  logic [DW-1:0] d_rdata;
  logic          d_valid;
  logic          mem_req;
  logic          mem_ready = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic          mem_we;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_rvalid = 1'b0;
  logic          err;

  always #5 clk = ~clk;

  imem_dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be), .d_we(d_we),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_req(mem_req), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .err(err)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Drive point: just after the rising edge. Checks follow a further #1.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog expired");
  end

  // Reference model state: pending requests and the last contested winner.
  bit      pend_f, pend_d;
  bit      win_d;          // 1 = data owns the current transaction
  bit      model_last_d;   // last contested winner was data
  bit      late;           // send a stray response in the next cycle
  bit      done, tmo;
  int      rd, rv;
  logic [DW-1:0] rval, exp_rd;

  initial begin
    pend_f = 0; pend_d = 0; model_last_d = 1; late = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_valids", {30'd0, if_valid, d_valid}, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    step();
    rst_n = 1'b1;

    for (int it = 0; it < 60; it++) begin
      step();
      mem_rvalid = late;
      mem_ready  = 1'($urandom);
      late = 0;
      // Raise new requests. it 0: fetch only, it 1: store only,
      // it 2..7: both kept asserted to exercise contention.
      if (!pend_f && it != 1 && (it == 0 || (it >= 2 && it <= 7) || ($urandom % 2) == 1)) begin
        pend_f  = 1;
        if_addr = (it == 0) ? 32'h100 : ($urandom & 32'hFFFF_FFFC);
      end
      if (!pend_d && it != 0 && (it >= 1 && it <= 7 || ($urandom % 2) == 1)) begin
        pend_d = 1;
        if (it == 1) begin
          d_addr = 32'h2004; d_wdata = 32'hDEADBEEF; d_be = 4'b0011; d_we = 1'b1;
        end else begin
          d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom); d_we = 1'($urandom);
        end
      end
      if_req = pend_f;
      d_req  = pend_d;
      #1;
      chk("idle_mem_req", 32'(mem_req), 32'd0);
      chk("idle_valids", {30'd0, if_valid, d_valid}, 32'd0);
      chk("idle_err", 32'(err), 32'd0);
      if (!pend_f && !pend_d) continue;

      // Winner from the arbitration rules.
      if (pend_f && pend_d) begin
`ifdef ARB_ROUND_ROBIN_EN
        win_d = !model_last_d;
`else
        win_d = 1;
`endif
        model_last_d = win_d;
      end else begin
        win_d = pend_d;
      end

      rd = (it < 2) ? 0 : (it == 8) ? 4 : $urandom_range(0, 4);
      rv = (it < 2) ? 1 : (it == 9) ? 5 : $urandom_range(1, 5);

      // REQ phase: fields stable while mem_req is up; stray responses ignored.
      for (int k = 0; k <= rd; k++) begin
        step();
        mem_ready  = (k == rd);
        mem_rvalid = 1'($urandom);
        mem_rdata  = $urandom;
        #1;
        chk("req_mem_req", 32'(mem_req), 32'd1);
        chk("req_mem_addr", mem_addr, win_d ? d_addr : if_addr);
        chk("req_mem_be", 32'(mem_be), win_d ? 32'(d_be) : 32'hF);
        chk("req_mem_we", 32'(mem_we), win_d ? 32'(d_we) : 32'd0);
        if (win_d) chk("req_mem_wdata", mem_wdata, d_wdata);
        chk("req_valids", {30'd0, if_valid, d_valid}, 32'd0);
        chk("req_err", 32'(err), 32'd0);
      end

      // WAIT phase: completion at the response or after TO cycles.
      rval = '0;
      for (int j = 1; j <= TO; j++) begin
        step();
        mem_ready  = 1'($urandom);
        mem_rvalid = (j == rv);
        mem_rdata  = (it == 0) ? 32'h0000_0013 : $urandom;
        if (j == rv) rval = mem_rdata;
        #1;
        done = (j == rv) || (j == TO);
        tmo  = (j == TO) && (rv > TO);
        exp_rd = tmo ? '0 : rval;
        chk("wait_mem_req", 32'(mem_req), 32'd0);
        chk("wait_if_valid", 32'(if_valid), 32'(done && !win_d));
        chk("wait_d_valid", 32'(d_valid), 32'(done && win_d));
        chk("wait_err", 32'(err), 32'(tmo));
        if (done) begin
          if (win_d) chk("d_rdata", d_rdata, exp_rd);
          else       chk("if_rdata", if_rdata, exp_rd);
          if (win_d) pend_d = 0; else pend_f = 0;
          late = tmo;
          break;
        end
      end
    end

    // Reset while waiting for a response.
    step();
    mem_rvalid = 0;
    if_req = 0; pend_f = 0;
    d_req = 1; d_addr = 32'h40; d_we = 0; d_be = 4'hF; pend_d = 1;
    step();
    mem_ready = 1;
    #1;
    chk("rw_mem_req", 32'(mem_req), 32'd1);
    step();
    mem_ready = 0;
    rst_n = 0;
    mem_rvalid = 1;
    #1;
    chk("rw_rst_valid", {30'd0, if_valid, d_valid}, 32'd0);
    chk("rw_rst_err", 32'(err), 32'd0);
    step();
    rst_n = 1;
    d_req = 0; pend_d = 0;
    mem_rvalid = 1;
    #1;
    chk("rw_after_mem_req", 32'(mem_req), 32'd0);
    chk("rw_after_valid", {30'd0, if_valid, d_valid}, 32'd0);
    chk("rw_after_addr", mem_addr, 32'd0);
    step();
    mem_rvalid = 0;
    if_req = 1; if_addr = 32'h0000_0A00;
    #1;
    chk("rw_idle_mem_req", 32'(mem_req), 32'd0);
    step();
    #1;
    chk("rw_new_mem_req", 32'(mem_req), 32'd1);
    chk("rw_new_addr", mem_addr, 32'h0000_0A00);
    chk("rw_new_valid", {30'd0, if_valid, d_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
